// File: rtl/uart_word_pkg.sv
// uart_word_pkg
//   Constants and types shared by the UART word serializer (TX) and the
//   receive-side byte assembler. Both ends must agree on the word geometry
//   and on the byte order (least-significant byte first).
//
//   NUM_BYTES : bytes per word
//   CNT_W     : byte-counter width, 2**CNT_W >= NUM_BYTES
//   WORD_W    : word width in bits
//   state_t   : serializer FSM state encoding

package uart_word_pkg;

    localparam int NUM_BYTES = 8;
    localparam int CNT_W     = 3;
    localparam int WORD_W    = NUM_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        WAIT_ACK = 3'd2,
        WAIT_TX  = 3'd3,
        DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/word_to_bytes_tx.sv
// word_to_bytes_tx
//   Takes one word per valid/ready handshake and hands it to the byte-level
//   UART transmitter as NUM_BYTES consecutive bytes, least-significant first.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | word_ready=1, waiting for word_valid
//   START    | tx_start pulse for the byte in shift_reg[7:0]
//   WAIT_ACK | waiting for the UART to raise tx_busy
//   WAIT_TX  | waiting for the UART to drop tx_busy (byte finished)
//   DONE     | word_done pulse, back to IDLE next cycle
//
//   Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   word_in    in   word to send, sampled only on acceptance
//   word_valid in   word_in is valid
//   word_ready out  idle, a word will be accepted this cycle
//   tx_data    out  byte presented to the UART TX (shift_reg[7:0])
//   tx_start   out  one-cycle request to send tx_data
//   tx_busy    in   UART TX is shifting a byte
//   word_done  out  one-cycle pulse after the last byte has completed

module word_to_bytes_tx #(
    parameter int NUM_BYTES = uart_word_pkg::NUM_BYTES,
    parameter int CNT_W     = uart_word_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BYTES*8-1:0] word_in,
    input  logic                   word_valid,
    output logic                   word_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   word_done
);

    import uart_word_pkg::*;

    localparam int W = NUM_BYTES * 8;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] byte_cnt;
    logic [W-1:0]     shift_reg;
    logic             accept;
    logic             byte_end;

    assign accept   = (state == IDLE) && word_valid;
    // The UART has finished the current byte: busy seen high, now low.
    assign byte_end = (state == WAIT_TX) && !tx_busy;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (word_valid) state_nxt = START;
            START:    state_nxt = WAIT_ACK;
            // busy may already be high on entry; that still counts as the ack
            WAIT_ACK: if (tx_busy) state_nxt = WAIT_TX;
            WAIT_TX:  if (!tx_busy) state_nxt = (byte_cnt == LAST_BYTE) ? DONE : START;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            shift_reg <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                shift_reg <= word_in;
                byte_cnt  <= '0;
            end else if (byte_end && (byte_cnt != LAST_BYTE)) begin
                // Advance to the next byte on the way back to START, so
                // tx_data is already updated when tx_start is raised.
                shift_reg <= {8'h00, shift_reg[W-1:8]};
                byte_cnt  <= byte_cnt + CNT_W'(1);
            end
        end
    end

    // All outputs decode registered state, so they are glitch-free and
    // tx_data cannot move while a byte is in flight.
    assign tx_data    = shift_reg[7:0];
    assign tx_start   = (state == START);
    assign word_done  = (state == DONE);
    assign word_ready = (state == IDLE);

endmodule
